// File: rtl/data_mem_access_unit_if.sv
// Pipeline request/response handshake and data_ram256x8 strobe bus.
// slave: the access unit. master: the pipeline plus RAM side.
interface data_mem_access_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        Fault;
  logic        Stall;
  logic        Enable;
  logic        ReadWrite;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [1:0]  Size;
  logic [31:0] RamDataOut;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RamDataOut,
    output ReqReady, RespValid, RespRData, Fault, Stall,
    output Enable, ReadWrite, Address, DataIn, Size
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RamDataOut,
    input  ReqReady, RespValid, RespRData, Fault, Stall,
    input  Enable, ReadWrite, Address, DataIn, Size
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store sequencer for data_ram256x8.
// One request at a time: setup, enable strobe, release, response.
// Misaligned, illegal-size and out-of-range requests are rejected at accept.
module data_mem_access_unit #(
  parameter int unsigned RAM_DEPTH  = 256,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic Clk,
  input  logic Reset,
  data_mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RELEASE, RESP, FAULT
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        wr_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [31:0] ld_q;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        bad;

  // Sign/zero extension of right-justified RAM read data.
  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  sz,
                                         input logic        sg);
    case (sz)
      2'b00:   extend = {{24{sg & raw[7]}},  raw[7:0]};
      2'b01:   extend = {{16{sg & raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Request legality: size, alignment and range (33-bit sum avoids wrap).
  always_comb begin
    nbytes = 3'd1;
    case (bus.ReqSize)
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    end_addr = {1'b0, bus.ReqAddr} + {30'd0, nbytes};
    bad = 1'b0;
    if (bus.ReqSize == 2'b11)                            bad = 1'b1;
    if (bus.ReqSize == 2'b01 && bus.ReqAddr[0])          bad = 1'b1;
    if (bus.ReqSize == 2'b10 && bus.ReqAddr[1:0] != 2'b00) bad = 1'b1;
    if (end_addr > 33'(RAM_DEPTH))                       bad = 1'b1;
  end

  // Sequencer with registered handshake and RAM strobe outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      wr_q          <= 1'b0;
      sgn_q         <= 1'b0;
      size_q        <= '0;
      ld_q          <= '0;
      bus.ReqReady  <= 1'b1;
      bus.RespValid <= 1'b0;
      bus.RespRData <= '0;
      bus.Fault     <= 1'b0;
      bus.Stall     <= 1'b0;
      bus.Enable    <= 1'b0;
      bus.ReadWrite <= 1'b0;
      bus.Address   <= '0;
      bus.DataIn    <= '0;
      bus.Size      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ReqReady is high throughout IDLE, so ReqValid alone is an accept.
          if (bus.ReqValid) begin
            bus.ReqReady <= 1'b0;
            bus.Stall    <= 1'b1;
            wr_q         <= bus.ReqWrite;
            sgn_q        <= bus.ReqSigned;
            size_q       <= bus.ReqSize;
            if (bad) begin
              state         <= FAULT;
              bus.RespValid <= 1'b1;
              bus.Fault     <= 1'b1;
              bus.RespRData <= '0;
            end else begin
              state         <= SETUP;
              cnt           <= '0;
              bus.Address   <= bus.ReqAddr;
              bus.Size      <= bus.ReqSize;
              bus.ReadWrite <= bus.ReqWrite;
              bus.DataIn    <= bus.ReqWData;
            end
          end
        end
        SETUP: begin
          if (cnt == 16'(SETUP_CYC - 1)) begin
            state      <= STROBE;
            cnt        <= '0;
            bus.Enable <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STROBE: begin
          if (cnt == 16'(STROBE_CYC - 1)) begin
            state      <= RELEASE;
            cnt        <= '0;
            bus.Enable <= 1'b0;
            ld_q       <= wr_q ? '0 : extend(bus.RamDataOut, size_q, sgn_q);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RELEASE: begin
          state         <= RESP;
          bus.RespValid <= 1'b1;
          bus.Fault     <= 1'b0;
          bus.RespRData <= ld_q;
          bus.Address   <= '0;
          bus.Size      <= '0;
          bus.ReadWrite <= 1'b0;
          bus.DataIn    <= '0;
        end
        RESP, FAULT: begin
          state         <= IDLE;
          bus.RespValid <= 1'b0;
          bus.Fault     <= 1'b0;
          bus.RespRData <= '0;
          bus.ReqReady  <= 1'b1;
          bus.Stall     <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.ReqReady  <= 1'b1;
          bus.Stall     <= 1'b0;
          bus.Enable    <= 1'b0;
          bus.RespValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit with a big-endian byte RAM model and
// a response scoreboard.
module tb_data_mem_access_unit;

  logic Clk;
  logic Reset;
  data_mem_access_unit_if bus ();

  data_mem_access_unit #(
    .RAM_DEPTH  (256),
    .SETUP_CYC  (1),
    .STROBE_CYC (1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        f;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [256];

  // RAM model: combinational big-endian read, write at the clock edge.
  always_comb begin
    logic [7:0] a;
    a = bus.Address[7:0];
    case (bus.Size)
      2'b00:   bus.RamDataOut = {24'd0, mem[a]};
      2'b01:   bus.RamDataOut = {16'd0, mem[a], mem[8'(a + 8'd1)]};
      default: bus.RamDataOut = {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
    endcase
  end

  always @(posedge Clk) begin
    if (bus.Enable && bus.ReadWrite) begin
      case (bus.Size)
        2'b00: mem[bus.Address[7:0]] <= bus.DataIn[7:0];
        2'b01: begin
          mem[bus.Address[7:0]]          <= bus.DataIn[15:8];
          mem[8'(bus.Address[7:0] + 1)]  <= bus.DataIn[7:0];
        end
        default: begin
          mem[bus.Address[7:0]]          <= bus.DataIn[31:24];
          mem[8'(bus.Address[7:0] + 1)]  <= bus.DataIn[23:16];
          mem[8'(bus.Address[7:0] + 2)]  <= bus.DataIn[15:8];
          mem[8'(bus.Address[7:0] + 3)]  <= bus.DataIn[7:0];
        end
      endcase
    end
  end

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge Clk) begin
    if (bus.RespValid) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_resp: got fault=%b data=%h, required no response", bus.Fault, bus.RespRData);
      end else begin
        e = sb.pop_front();
        if ({bus.Fault, bus.RespRData} !== {e.f, e.d}) begin
          errors++;
          $display("FAIL sb_resp: got fault=%b data=%h, required fault=%b data=%h",
                   bus.Fault, bus.RespRData, e.f, e.d);
        end
      end
    end
  end

  // Drives one request, scrambles Req* after accept, and measures timing.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_f,
                       output int lat, output int en_cyc, output int stall_low);
    int guard;
    exp_t e;
    lat = -1; en_cyc = 0; stall_low = 0; guard = 0;
    @(negedge Clk);
    while (!bus.ReqReady && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = wr;
    bus.ReqSize   = sz;
    bus.ReqSigned = sg;
    bus.ReqAddr   = addr;
    bus.ReqWData  = wd;
    e.f = exp_f;
    e.d = exp_d;
    sb.push_back(e);
    for (int k = 1; k <= 50; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'($urandom);
        bus.ReqSize   = 2'($urandom);
        bus.ReqSigned = 1'($urandom);
        bus.ReqAddr   = $urandom;
        bus.ReqWData  = $urandom;
      end
      if (bus.Enable) en_cyc++;
      if (!bus.Stall) stall_low++;
      if (bus.RespValid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({bus.ReqReady, bus.Enable, bus.RespValid, bus.Fault, bus.Stall} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/en/rv/flt/stall=%b, required 10000",
               {bus.ReqReady, bus.Enable, bus.RespValid, bus.Fault, bus.Stall});
    end
    checks++;
    if ({bus.Address, bus.DataIn, bus.Size, bus.ReadWrite, bus.RespRData} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h din=%h size=%b rw=%b rdata=%h, required all zero",
               bus.Address, bus.DataIn, bus.Size, bus.ReadWrite, bus.RespRData);
    end
    Reset = 1'b1;
  endtask

  task automatic test_word_load();
    int lat, en, sl;
    issue(1'b0, 2'b10, 1'b0, 32'd0, '0, 32'h853CF210, 1'b0, lat, en, sl);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL word_lat: got %0d, required 4", lat); end
    checks++;
    if (en !== 1) begin errors++; $display("FAIL word_enable_cycles: got %0d, required 1", en); end
    checks++;
    if (sl !== 0) begin errors++; $display("FAIL word_stall: got %0d low cycles, required 0", sl); end
  endtask

  task automatic test_byte_load();
    int lat, en, sl;
    issue(1'b0, 2'b00, 1'b1, 32'd0, '0, 32'hFFFFFF85, 1'b0, lat, en, sl);
    issue(1'b0, 2'b00, 1'b0, 32'd0, '0, 32'h00000085, 1'b0, lat, en, sl);
    issue(1'b0, 2'b00, 1'b1, 32'd1, '0, 32'h0000003C, 1'b0, lat, en, sl);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL byte_lat: got %0d, required 4", lat); end
  endtask

  task automatic test_store_half();
    int lat, en, sl;
    issue(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000FFD3, 32'd0, 1'b0, lat, en, sl);
    checks++;
    if (lat !== 4 || en !== 1) begin
      errors++;
      $display("FAIL store_timing: got lat=%0d en=%0d, required lat=4 en=1", lat, en);
    end
    issue(1'b0, 2'b01, 1'b1, 32'd2, '0, 32'hFFFFFFD3, 1'b0, lat, en, sl);
    issue(1'b0, 2'b01, 1'b0, 32'd2, '0, 32'h0000FFD3, 1'b0, lat, en, sl);
    issue(1'b0, 2'b10, 1'b0, 32'd0, '0, 32'h853CFFD3, 1'b0, lat, en, sl);
  endtask

  task automatic test_faults();
    int lat, en, sl;
    issue(1'b0, 2'b10, 1'b0, 32'd6, '0, 32'd0, 1'b1, lat, en, sl);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL fault_lat: got %0d, required 1", lat); end
    checks++;
    if (en !== 0) begin errors++; $display("FAIL fault_enable: got %0d cycles, required 0", en); end
    issue(1'b0, 2'b11, 1'b0, 32'd0, '0, 32'd0, 1'b1, lat, en, sl);
    issue(1'b0, 2'b01, 1'b1, 32'd1, '0, 32'd0, 1'b1, lat, en, sl);
    issue(1'b1, 2'b10, 1'b0, 32'd2, 32'hDEADBEEF, 32'd0, 1'b1, lat, en, sl);
    checks++;
    if (en !== 0) begin errors++; $display("FAIL fault_store_enable: got %0d cycles, required 0", en); end
  endtask

  task automatic test_boundary();
    int lat, en, sl;
    issue(1'b0, 2'b10, 1'b0, 32'd252, '0, 32'h59585B5A, 1'b0, lat, en, sl);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL word252_lat: got %0d, required 4", lat); end
    issue(1'b0, 2'b10, 1'b0, 32'd256, '0, 32'd0, 1'b1, lat, en, sl);
    issue(1'b0, 2'b00, 1'b1, 32'd255, '0, 32'h0000005A, 1'b0, lat, en, sl);
    issue(1'b0, 2'b01, 1'b0, 32'd254, '0, 32'h00005B5A, 1'b0, lat, en, sl);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, '0, 32'd0, 1'b1, lat, en, sl);
  endtask

  task automatic test_back_to_back();
    int acc [3];
    logic stall_h [60];
    int n, hi;
    logic [31:0] addrs [3];
    logic [31:0] exps [3];
    exp_t e;
    addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd8;
    exps[0] = 32'h853CFFD3; exps[1] = 32'h00112233; exps[2] = 32'hADACAFAE;
    acc[0] = -100; acc[1] = -100; acc[2] = -100;
    n = 0;
    bus.ReqWrite = 1'b0; bus.ReqSize = 2'b10; bus.ReqSigned = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      stall_h[c] = bus.Stall;
      if (n == 3) bus.ReqValid = 1'b0;
      if (bus.ReqReady && n < 3) begin
        bus.ReqValid = 1'b1;
        bus.ReqAddr  = addrs[n];
        e.f = 1'b0;
        e.d = exps[n];
        sb.push_back(e);
        acc[n] = c;
        n++;
      end
      if (n == 3 && sb.size() == 0) break;
    end
    bus.ReqValid = 1'b0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d, required 3", n); end
    checks++;
    if (acc[1] - acc[0] !== 5 || acc[2] - acc[1] !== 5) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d cycles, required 5,5", acc[1] - acc[0], acc[2] - acc[1]);
    end
    hi = 0;
    for (int c = 0; c < 60; c++)
      if (c > acc[0] && c < acc[2] && stall_h[c]) hi++;
    checks++;
    if (hi !== 8) begin errors++; $display("FAIL b2b_stall: got %0d high cycles, required 8", hi); end
  endtask

  task automatic test_reset_mid_access();
    int lat, en, sl, guard;
    guard = 0;
    @(negedge Clk);
    while (!bus.ReqReady && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b10;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 32'd0;
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.Enable !== 1'b1) begin errors++; $display("FAIL midrst_strobe: got en=%b, required 1", bus.Enable); end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({bus.Enable, bus.Stall, bus.ReqReady, bus.RespValid} !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_async: got en/stall/rdy/rv=%b, required 0010",
               {bus.Enable, bus.Stall, bus.ReqReady, bus.RespValid});
    end
    @(negedge Clk);
    Reset = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'd4, '0, 32'h00112233, 1'b0, lat, en, sl);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL midrst_reload_lat: got %0d, required 4", lat); end
  endtask

  initial begin
    mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'hF2; mem[3] = 8'h10;
    mem[4] = 8'h00; mem[5] = 8'h11; mem[6] = 8'h22; mem[7] = 8'h33;
    for (int i = 8; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b00;
    bus.ReqSigned = 1'b0; bus.ReqAddr = '0; bus.ReqWData = '0;
    Reset = 1'b0;

    test_reset();
    test_word_load();
    test_byte_load();
    test_store_half();
    test_faults();
    test_boundary();
    test_back_to_back();
    test_reset_mid_access();

    repeat (2) @(negedge Clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
